// File: rtl/stack_arbiter.sv
// stack_arbiter: shares one LIFO stack between requesters A and B, tracking occupancy
// so overflow/underflow are rejected without the stack's own flags.
// Macro STACK_ARB_PRIO_EN: when defined, A has fixed priority over B and the
// round-robin pointer is removed; when undefined, arbitration is round-robin.
module stack_arbiter #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              Req_A,
    input  logic              Op_A,
    input  logic [DATA_W-1:0] Din_A,
    output logic              Gnt_A,
    output logic              Err_A,
    output logic [DATA_W-1:0] Dout_A,
    input  logic              Req_B,
    input  logic              Op_B,
    input  logic [DATA_W-1:0] Din_B,
    output logic              Gnt_B,
    output logic              Err_B,
    output logic [DATA_W-1:0] Dout_B,
    output logic              Stk_Push,
    output logic              Stk_Pop,
    output logic [DATA_W-1:0] Stk_Data_In,
    input  logic [DATA_W-1:0] Stk_Data_Out,
    output logic [CNT_W-1:0]  Count,
    output logic              Full,
    output logic              Empty
);
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, DONE, REJECT} state_t;

    state_t            state, state_nxt;
    logic              win_b;
    logic              op_pop;
    logic [DATA_W-1:0] din_l;
    logic [DATA_W-1:0] dout_a, dout_b;
    logic [CNT_W-1:0]  count;
    logic              any_req, pick_b, pick_pop, reject;
    logic [DATA_W-1:0] pick_din;

    assign any_req  = Req_A || Req_B;
    assign pick_pop = pick_b ? Op_B : Op_A;
    assign pick_din = pick_b ? Din_B : Din_A;
    assign reject   = pick_pop ? (count == '0) : (count == CNT_W'(DEPTH));

`ifdef STACK_ARB_PRIO_EN
    assign pick_b = Req_B && !Req_A;
`else
    logic last_b;

    assign pick_b = Req_B && (!Req_A || !last_b);

    // Remember who was served last (rejections included); reset value favours A.
    always_ff @(posedge Clk or negedge RstN)
        if (!RstN)
            last_b <= 1'b1;
        else if (state == IDLE && any_req)
            last_b <= pick_b;
`endif

    // Next state: every non-idle state lasts one cycle.
    always_comb begin
        state_nxt = IDLE;
        state_nxt = (state == IDLE)    ? (!any_req ? IDLE : (reject ? REJECT : ISSUE)) :
                    (state == ISSUE)   ? CAPTURE :
                    (state == CAPTURE) ? DONE : IDLE;
    end

    // State, latched winner request, occupancy and per-requester pop data.
    always_ff @(posedge Clk or negedge RstN)
        if (!RstN) begin
            state  <= IDLE;
            win_b  <= 1'b0;
            op_pop <= 1'b0;
            din_l  <= '0;
            count  <= '0;
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                win_b  <= pick_b;
                op_pop <= pick_pop;
                din_l  <= pick_din;
            end
            if (state == ISSUE)
                count <= op_pop ? count - CNT_W'(1) : count + CNT_W'(1);
            if (state == CAPTURE && op_pop && !win_b)
                dout_a <= Stk_Data_Out;
            if (state == CAPTURE && op_pop && win_b)
                dout_b <= Stk_Data_Out;
        end

    assign Stk_Push    = (state == ISSUE) && !op_pop;
    assign Stk_Pop     = (state == ISSUE) && op_pop;
    assign Stk_Data_In = (state == ISSUE) ? din_l : '0;
    assign Gnt_A       = (state == DONE) && !win_b;
    assign Gnt_B       = (state == DONE) && win_b;
    assign Err_A       = (state == REJECT) && !win_b;
    assign Err_B       = (state == REJECT) && win_b;
    assign Dout_A      = dout_a;
    assign Dout_B      = dout_b;
    assign Count       = count;
    assign Full        = (count == CNT_W'(DEPTH));
    assign Empty       = (count == '0);

    a_strobe_excl: assert property (@(posedge Clk) disable iff (!RstN) !(Stk_Push && Stk_Pop));
    a_count_range: assert property (@(posedge Clk) disable iff (!RstN) count <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: randomized and directed checks of stack_arbiter against a queue-based model.
module tb_stack_arbiter;
    logic       Clk = 1'b0;
    logic       RstN = 1'b0;
    logic       Req_A, Op_A, Req_B, Op_B;
    logic [3:0] Din_A, Din_B, Dout_A, Dout_B;
    logic       Gnt_A, Err_A, Gnt_B, Err_B;
    logic       Stk_Push, Stk_Pop, Full, Empty;
    logic [3:0] Stk_Data_In, Stk_Data_Out, Count;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] stk_q[$];
    logic [3:0] mdout[2];
    bit         last_b;

    int         o_lat;
    bit         o_ga, o_ea, o_gb, o_eb, o_push, o_pop, o_both;
    logic [3:0] o_sdi;

    logic [3:0] mem[8];
    int         sp;

    stack_arbiter dut (
        .Clk(Clk), .RstN(RstN),
        .Req_A(Req_A), .Op_A(Op_A), .Din_A(Din_A), .Gnt_A(Gnt_A), .Err_A(Err_A), .Dout_A(Dout_A),
        .Req_B(Req_B), .Op_B(Op_B), .Din_B(Din_B), .Gnt_B(Gnt_B), .Err_B(Err_B), .Dout_B(Dout_B),
        .Stk_Push(Stk_Push), .Stk_Pop(Stk_Pop), .Stk_Data_In(Stk_Data_In), .Stk_Data_Out(Stk_Data_Out),
        .Count(Count), .Full(Full), .Empty(Empty)
    );

    always #5 Clk = ~Clk;

    // Attached stack: data out is valid the cycle after a pop strobe.
    always @(posedge Clk or negedge RstN)
        if (!RstN) begin
            sp <= 0;
            Stk_Data_Out <= '0;
        end else if (Stk_Push && sp < 8) begin
            mem[sp] <= Stk_Data_In;
            sp <= sp + 1;
        end else if (Stk_Pop && sp > 0) begin
            Stk_Data_Out <= mem[sp-1];
            sp <= sp - 1;
        end

    task automatic model_reset();
        stk_q.delete();
        mdout[0] = '0;
        mdout[1] = '0;
        last_b = 1'b1;
    endtask

    task automatic model_step(input bit ra, input bit rb, input bit oa, input bit ob,
                              input logic [3:0] da, input logic [3:0] db, output bit wb, output bit rej);
        bit op;
        logic [3:0] d;
`ifdef STACK_ARB_PRIO_EN
        wb = rb && !ra;
`else
        wb = rb && (!ra || !last_b);
`endif
        op = wb ? ob : oa;
        d = wb ? db : da;
        rej = op ? (stk_q.size() == 0) : (stk_q.size() == 8);
        if (!rej && op) begin
            mdout[wb] = stk_q[$];
            stk_q.pop_back();
        end else if (!rej) begin
            stk_q.push_back(d);
        end
        last_b = wb;
    endtask

    task automatic drive(input bit ra, input bit rb, input bit oa, input bit ob,
                         input logic [3:0] da, input logic [3:0] db);
        @(negedge Clk);
        Req_A = ra; Req_B = rb; Op_A = oa; Op_B = ob; Din_A = da; Din_B = db;
        o_lat = 0;
        {o_ga, o_ea, o_gb, o_eb, o_push, o_pop, o_both} = '0;
        o_sdi = '0;
        do begin
            @(negedge Clk);
            o_lat++;
            o_push |= Stk_Push;
            o_pop  |= Stk_Pop;
            o_both |= Stk_Push && Stk_Pop;
            if (Stk_Push) o_sdi = Stk_Data_In;
            o_ga = Gnt_A; o_ea = Err_A; o_gb = Gnt_B; o_eb = Err_B;
        end while (!(o_ga || o_ea || o_gb || o_eb) && o_lat < 20);
        Req_A = 1'b0;
        Req_B = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        RstN = 1'b0;
        @(negedge Clk);
        RstN = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        vectors++;
        if (Count !== 4'd0 || Empty !== 1'b1 || Full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: Count=%0d Empty=%b Full=%b, want 0 1 0", Count, Empty, Full);
        end
        vectors++;
        if (Dout_A !== 4'h0 || Dout_B !== 4'h0 || Stk_Data_In !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_data: Dout_A=%h Dout_B=%h Stk_Data_In=%h, want 0 0 0", Dout_A, Dout_B, Stk_Data_In);
        end
        vectors++;
        if ({Gnt_A, Err_A, Gnt_B, Err_B, Stk_Push, Stk_Pop} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 000000", {Gnt_A, Err_A, Gnt_B, Err_B, Stk_Push, Stk_Pop});
        end
        @(negedge Clk);
        RstN = 1'b1;
        model_reset();
    endtask

    task automatic test_push_pop();
        bit wb, rej;
        drive(1, 0, 0, 0, 4'h3, 4'h0);
        model_step(1, 0, 0, 0, 4'h3, 4'h0, wb, rej);
        vectors++;
        if (!o_ga || o_gb || o_lat != 3 || !o_push || o_sdi !== 4'h3 || Count !== 4'd1) begin
            miscompares++;
            $display("FAIL push_a: gnt=%b lat=%0d push=%b data=%h Count=%0d, want 1 3 1 3 1", o_ga, o_lat, o_push, o_sdi, Count);
        end
        drive(0, 1, 0, 0, 4'h0, 4'h9);
        model_step(0, 1, 0, 0, 4'h0, 4'h9, wb, rej);
        vectors++;
        if (!o_gb || o_ga || o_lat != 3 || !o_push || o_sdi !== 4'h9 || Count !== 4'd2) begin
            miscompares++;
            $display("FAIL push_b: gnt=%b lat=%0d push=%b data=%h Count=%0d, want 1 3 1 9 2", o_gb, o_lat, o_push, o_sdi, Count);
        end
        drive(1, 0, 1, 0, 4'h0, 4'h0);
        model_step(1, 0, 1, 0, 4'h0, 4'h0, wb, rej);
        vectors++;
        if (!o_ga || o_lat != 3 || !o_pop || o_push || Count !== 4'd1) begin
            miscompares++;
            $display("FAIL pop_a: gnt=%b lat=%0d pop=%b push=%b Count=%0d, want 1 3 1 0 1", o_ga, o_lat, o_pop, o_push, Count);
        end
        vectors++;
        if (Dout_A !== mdout[0] || Dout_B !== mdout[1]) begin
            miscompares++;
            $display("FAIL pop_a_data: Dout_A=%h Dout_B=%h, want %h %h", Dout_A, Dout_B, mdout[0], mdout[1]);
        end
    endtask

    task automatic test_overflow();
        bit wb, rej;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1, 0, 0, 0, 4'(i), 4'h0);
            model_step(1, 0, 0, 0, 4'(i), 4'h0, wb, rej);
            vectors++;
            if (!o_ga || o_lat != 3 || o_sdi !== 4'(i) || Count !== 4'(i)) begin
                miscompares++;
                $display("FAIL fill_%0d: gnt=%b lat=%0d data=%h Count=%0d", i, o_ga, o_lat, o_sdi, Count);
            end
        end
        vectors++;
        if (Full !== 1'b1 || Empty !== 1'b0) begin
            miscompares++;
            $display("FAIL full_flag: Full=%b Empty=%b, want 1 0", Full, Empty);
        end
        drive(1, 0, 0, 0, 4'hF, 4'h0);
        model_step(1, 0, 0, 0, 4'hF, 4'h0, wb, rej);
        vectors++;
        if (!o_ea || o_ga || o_lat != 1 || o_push || Count !== 4'd8) begin
            miscompares++;
            $display("FAIL overflow: err=%b gnt=%b lat=%0d push=%b Count=%0d, want 1 0 1 0 8", o_ea, o_ga, o_lat, o_push, Count);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 1, 0, 4'h0, 4'h0);
            model_step(1, 0, 1, 0, 4'h0, 4'h0, wb, rej);
            vectors++;
            if (!o_ga || Dout_A !== mdout[0] || Count !== 4'(stk_q.size())) begin
                miscompares++;
                $display("FAIL drain_%0d: gnt=%b Dout_A=%h Count=%0d, want 1 %h %0d", i, o_ga, Dout_A, Count, mdout[0], stk_q.size());
            end
        end
        vectors++;
        if (Empty !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_flag: Empty=%b want 1", Empty);
        end
    endtask

    task automatic test_underflow();
        bit wb, rej;
        drive(0, 1, 0, 0, 4'h0, 4'h5);
        model_step(0, 1, 0, 0, 4'h0, 4'h5, wb, rej);
        drive(0, 1, 0, 1, 4'h0, 4'h0);
        model_step(0, 1, 0, 1, 4'h0, 4'h0, wb, rej);
        vectors++;
        if (!o_gb || Dout_B !== 4'h5) begin
            miscompares++;
            $display("FAIL pop_b: gnt=%b Dout_B=%h, want 1 5", o_gb, Dout_B);
        end
        drive(0, 1, 0, 1, 4'h0, 4'h0);
        model_step(0, 1, 0, 1, 4'h0, 4'h0, wb, rej);
        vectors++;
        if (!o_eb || o_gb || o_lat != 1 || o_pop || Dout_B !== 4'h5 || Count !== 4'd0) begin
            miscompares++;
            $display("FAIL underflow: err=%b gnt=%b lat=%0d pop=%b Dout_B=%h Count=%0d, want 1 0 1 0 5 0", o_eb, o_gb, o_lat, o_pop, Dout_B, Count);
        end
    endtask

    task automatic test_back_to_back();
        bit wb, rej;
        int n = 0;
        int cyc = 0;
        int last = 0;
        do_reset();
        @(negedge Clk);
        Req_A = 1; Req_B = 1; Op_A = 0; Op_B = 0; Din_A = 4'hA; Din_B = 4'h5;
        while (n < 8 && cyc < 100) begin
            @(negedge Clk);
            cyc++;
            if (Gnt_A || Gnt_B) begin
                model_step(1, 1, 0, 0, 4'hA, 4'h5, wb, rej);
                vectors++;
                if (Gnt_B !== wb || Gnt_A === Gnt_B || cyc - last != (n == 0 ? 3 : 4)) begin
                    miscompares++;
                    $display("FAIL b2b_grant_%0d: Gnt_A=%b Gnt_B=%b gap=%0d, want B=%b gap=%0d", n, Gnt_A, Gnt_B, cyc - last, wb, n == 0 ? 3 : 4);
                end
                last = cyc;
                n++;
                if (n == 8) begin
                    Req_A = 0;
                    Req_B = 0;
                end
            end
        end
        Req_A = 0;
        Req_B = 0;
        vectors++;
        if (n != 8 || Count !== 4'd8 || Full !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_end: grants=%0d Count=%0d Full=%b, want 8 8 1", n, Count, Full);
        end
    endtask

    task automatic test_reset_mid();
        bit wb, rej;
        bit bad = 0;
        @(negedge Clk);
        Req_A = 1; Op_A = 1; Req_B = 0;
        @(negedge Clk);
        vectors++;
        if (Stk_Pop !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_issue: Stk_Pop=%b want 1", Stk_Pop);
        end
        @(negedge Clk);
        RstN = 1'b0;
        #1;
        vectors++;
        if (Count !== 4'd0 || Empty !== 1'b1 || Full !== 1'b0 || Dout_A !== 4'h0 || Dout_B !== 4'h0 ||
            {Gnt_A, Err_A, Gnt_B, Err_B, Stk_Push, Stk_Pop} !== 6'b0 || Stk_Data_In !== 4'h0) begin
            miscompares++;
            $display("FAIL mid_reset: Count=%0d Empty=%b Full=%b Dout_A=%h strobes=%b, want reset values",
                     Count, Empty, Full, Dout_A, {Gnt_A, Err_A, Gnt_B, Err_B, Stk_Push, Stk_Pop});
        end
        Req_A = 0;
        model_reset();
        repeat (2) begin
            @(negedge Clk);
            bad |= Gnt_A || Err_A;
        end
        RstN = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL mid_no_gnt: got a grant/error during reset, want none");
        end
        drive(1, 0, 0, 0, 4'h6, 4'h0);
        model_step(1, 0, 0, 0, 4'h6, 4'h0, wb, rej);
        vectors++;
        if (!o_ga || o_lat != 3 || o_sdi !== 4'h6 || Count !== 4'd1) begin
            miscompares++;
            $display("FAIL mid_after: gnt=%b lat=%0d data=%h Count=%0d, want 1 3 6 1", o_ga, o_lat, o_sdi, Count);
        end
    endtask

    task automatic test_random();
        bit wb, rej, ra, rb, oa, ob, op;
        logic [3:0] da, db, d;
        for (int i = 0; i < 60; i++) begin
            ra = 1; rb = 1;
            if ($urandom_range(0, 2) != 0) begin
                ra = $urandom_range(0, 1) == 1;
                rb = !ra;
            end
            oa = $urandom_range(0, 1) == 1;
            ob = $urandom_range(0, 1) == 1;
            da = 4'($urandom);
            db = 4'($urandom);
            drive(ra, rb, oa, ob, da, db);
            model_step(ra, rb, oa, ob, da, db, wb, rej);
            op = wb ? ob : oa;
            d = wb ? db : da;
            vectors++;
            if (o_ga !== (!wb && !rej) || o_ea !== (!wb && rej) || o_gb !== (wb && !rej) || o_eb !== (wb && rej) ||
                o_lat != (rej ? 1 : 3)) begin
                miscompares++;
                $display("FAIL rand_%0d_resp: ga=%b ea=%b gb=%b eb=%b lat=%0d, want winner_b=%b reject=%b", i, o_ga, o_ea, o_gb, o_eb, o_lat, wb, rej);
            end
            vectors++;
            if (o_push !== (!rej && !op) || o_pop !== (!rej && op) || o_both || (o_push && o_sdi !== d)) begin
                miscompares++;
                $display("FAIL rand_%0d_strobe: push=%b pop=%b both=%b data=%h, want push=%b pop=%b data=%h", i, o_push, o_pop, o_both, o_sdi, !rej && !op, !rej && op, d);
            end
            vectors++;
            if (Count !== 4'(stk_q.size()) || Empty !== (stk_q.size() == 0) || Full !== (stk_q.size() == 8) ||
                Dout_A !== mdout[0] || Dout_B !== mdout[1]) begin
                miscompares++;
                $display("FAIL rand_%0d_state: Count=%0d Dout_A=%h Dout_B=%h, want %0d %h %h", i, Count, Dout_A, Dout_B, stk_q.size(), mdout[0], mdout[1]);
            end
        end
    endtask

    initial begin
        Req_A = 0; Op_A = 0; Din_A = '0;
        Req_B = 0; Op_B = 0; Din_B = '0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
